// File: rtl/mul_sequencer_if.sv
// Issue/result bundle between the execute stage, the multiplier and mul_sequencer.
// The sequencer sits on the slave side of this interface.
interface mul_sequencer_if;
   logic        start;
   logic [2:0]  cmd;
   logic [3:0]  rd_lo;
   logic [3:0]  rd_hi;
   logic        flush;
   logic [31:0] mul_y;
   logic [31:0] mul_aux;
   logic        mul_op;
   logic [2:0]  mul_cmd;
   logic        busy;
   logic        we;
   logic [3:0]  wa;
   logic [31:0] wd;
   logic        done;
   logic        err;

   modport master (
      output start, cmd, rd_lo, rd_hi, flush, mul_y, mul_aux,
      input  mul_op, mul_cmd, busy, we, wa, wd, done, err
   );

   modport slave (
      input  start, cmd, rd_lo, rd_hi, flush, mul_y, mul_aux,
      output mul_op, mul_cmd, busy, we, wa, wd, done, err
   );
endinterface

// File: rtl/mul_sequencer.sv
// Holds one multiply in flight for LATENCY cycles, then retires its result
// through the single register-file write port (one write, or RdLo then RdHi).
module mul_sequencer #(
   parameter int unsigned LATENCY = 2
) (
   input  logic           clk,
   input  logic           reset,
   mul_sequencer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, WAIT, WB_LO, WB_HI} state_t;

   state_t      state;
   logic [2:0]  cmd_q;
   logic [3:0]  rd_lo_q;
   logic [3:0]  rd_hi_q;
   logic [3:0]  cnt;
   logic [31:0] lo_q;
   logic [31:0] hi_q;
   logic        cmd_legal;

   assign cmd_legal = (bus.cmd[2:1] != 2'b01);

   // Outputs are set for the state being entered, so they are plain flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cmd_q       <= '0;
         rd_lo_q     <= '0;
         rd_hi_q     <= '0;
         cnt         <= '0;
         lo_q        <= '0;
         hi_q        <= '0;
         bus.mul_op  <= 1'b0;
         bus.mul_cmd <= '0;
         bus.busy    <= 1'b0;
         bus.we      <= 1'b0;
         bus.wa      <= '0;
         bus.done    <= 1'b0;
         bus.err     <= 1'b0;
      end else begin
         bus.mul_op  <= 1'b0;
         bus.mul_cmd <= '0;
         bus.busy    <= 1'b0;
         bus.we      <= 1'b0;
         bus.wa      <= '0;
         bus.done    <= 1'b0;
         bus.err     <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start && !bus.flush) begin
                  if (cmd_legal) begin
                     cmd_q       <= bus.cmd;
                     rd_lo_q     <= bus.rd_lo;
                     rd_hi_q     <= bus.rd_hi;
                     cnt         <= 4'(LATENCY - 1);
                     state       <= WAIT;
                     bus.busy    <= 1'b1;
                     bus.mul_op  <= 1'b1;
                     bus.mul_cmd <= bus.cmd;
                  end else begin
                     bus.err <= 1'b1;
                  end
               end
            end
            WAIT: begin
               if (bus.flush) begin
                  state <= IDLE;
               end else if (cnt == 4'd0) begin
                  lo_q     <= bus.mul_y;
                  hi_q     <= bus.mul_aux;
                  state    <= WB_LO;
                  bus.busy <= 1'b1;
                  bus.we   <= 1'b1;
                  bus.wa   <= rd_lo_q;
                  bus.done <= !cmd_q[2];
               end else begin
                  cnt         <= cnt - 4'd1;
                  bus.busy    <= 1'b1;
                  bus.mul_op  <= 1'b1;
                  bus.mul_cmd <= cmd_q;
               end
            end
            WB_LO: begin
               if (cmd_q[2]) begin
                  state    <= WB_HI;
                  bus.busy <= 1'b1;
                  bus.we   <= 1'b1;
                  bus.wa   <= rd_hi_q;
                  bus.done <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            WB_HI: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Write data is selected from the captured words by the current state only.
   always_comb begin
      bus.wd = '0;
      case (state)
         WB_LO:   bus.wd = lo_q;
         WB_HI:   bus.wd = hi_q;
         default: bus.wd = '0;
      endcase
   end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed checks of mul_sequencer at LATENCY=2 (table plus corner sequences)
// and at LATENCY=1 (back-to-back issue).
module tb_mul_sequencer;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   mul_sequencer_if if0 ();
   mul_sequencer_if if1 ();

   mul_sequencer #(.LATENCY(2)) dut0 (.clk(clk), .reset(reset), .bus(if0));
   mul_sequencer #(.LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

   typedef struct {
      logic [2:0]  cmd;
      logic [3:0]  rd_lo;
      logic [3:0]  rd_hi;
      logic [31:0] y;
      logic [31:0] aux;
      logic        illegal;
      logic        long_op;
      logic [3:0]  wa0;
      logic [3:0]  wa1;
      logic [31:0] wd0;
      logic [31:0] wd1;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk_idle0(input string name);
      chk({name, ".busy"},    32'(if0.busy),    32'd0);
      chk({name, ".mul_op"},  32'(if0.mul_op),  32'd0);
      chk({name, ".mul_cmd"}, 32'(if0.mul_cmd), 32'd0);
      chk({name, ".we"},      32'(if0.we),      32'd0);
      chk({name, ".wa"},      32'(if0.wa),      32'd0);
      chk({name, ".wd"},      if0.wd,           32'd0);
      chk({name, ".done"},    32'(if0.done),    32'd0);
      chk({name, ".err"},     32'(if0.err),     32'd0);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      string n;
      n = $sformatf("vec%0d", idx);
      @(negedge clk);
      if0.start = 1'b1; if0.cmd = v.cmd; if0.rd_lo = v.rd_lo; if0.rd_hi = v.rd_hi;
      if0.mul_y = v.y;  if0.mul_aux = v.aux;
      @(negedge clk);
      if0.start = 1'b0;
      if (v.illegal) begin
         chk({n, ".c1.err"},  32'(if0.err),    32'd1);
         chk({n, ".c1.busy"}, 32'(if0.busy),   32'd0);
         chk({n, ".c1.mop"},  32'(if0.mul_op), 32'd0);
         chk({n, ".c1.we"},   32'(if0.we),     32'd0);
         @(negedge clk);
         chk_idle0({n, ".c2"});
         @(negedge clk);
         chk_idle0({n, ".c3"});
      end else begin
         for (int c = 1; c <= 2; c++) begin
            chk($sformatf("%s.c%0d.busy", n, c), 32'(if0.busy),    32'd1);
            chk($sformatf("%s.c%0d.mop", n, c),  32'(if0.mul_op),  32'd1);
            chk($sformatf("%s.c%0d.mcmd", n, c), 32'(if0.mul_cmd), 32'(v.cmd));
            chk($sformatf("%s.c%0d.we", n, c),   32'(if0.we),      32'd0);
            @(negedge clk);
         end
         chk({n, ".c3.busy"}, 32'(if0.busy),    32'd1);
         chk({n, ".c3.mop"},  32'(if0.mul_op),  32'd0);
         chk({n, ".c3.mcmd"}, 32'(if0.mul_cmd), 32'd0);
         chk({n, ".c3.we"},   32'(if0.we),      32'd1);
         chk({n, ".c3.wa"},   32'(if0.wa),      32'(v.wa0));
         chk({n, ".c3.wd"},   if0.wd,           v.wd0);
         chk({n, ".c3.done"}, 32'(if0.done),    32'(!v.long_op));
         @(negedge clk);
         if (v.long_op) begin
            chk({n, ".c4.busy"}, 32'(if0.busy), 32'd1);
            chk({n, ".c4.we"},   32'(if0.we),   32'd1);
            chk({n, ".c4.wa"},   32'(if0.wa),   32'(v.wa1));
            chk({n, ".c4.wd"},   if0.wd,        v.wd1);
            chk({n, ".c4.done"}, 32'(if0.done), 32'd1);
            @(negedge clk);
            chk_idle0({n, ".c5"});
         end else begin
            chk_idle0({n, ".c4"});
         end
      end
   endtask

   initial begin
      //          cmd     rd_lo  rd_hi  y             aux           ill   long  wa0    wa1    wd0           wd1
      vecs[0] = '{3'b000, 4'd3,  4'd0,  32'h0000_0006, 32'h0000_0000, 1'b0, 1'b0, 4'd3,  4'd0,  32'h0000_0006, 32'h0};
      vecs[1] = '{3'b100, 4'd4,  4'd5,  32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1, 4'd4,  4'd5,  32'hFFFF_FFFE, 32'h0000_0001};
      vecs[2] = '{3'b001, 4'd15, 4'd9,  32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0, 4'd15, 4'd0,  32'hDEAD_BEEF, 32'h0};
      vecs[3] = '{3'b110, 4'd7,  4'd7,  32'h1111_1111, 32'h2222_2222, 1'b0, 1'b1, 4'd7,  4'd7,  32'h1111_1111, 32'h2222_2222};
      vecs[4] = '{3'b010, 4'd1,  4'd2,  32'hAAAA_AAAA, 32'hBBBB_BBBB, 1'b1, 1'b0, 4'd0,  4'd0,  32'h0,         32'h0};
      vecs[5] = '{3'b011, 4'd6,  4'd8,  32'hCCCC_CCCC, 32'hDDDD_DDDD, 1'b1, 1'b0, 4'd0,  4'd0,  32'h0,         32'h0};
      vecs[6] = '{3'b111, 4'd0,  4'd14, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'd0,  4'd14, 32'h0,         32'hFFFF_FFFF};
      vecs[7] = '{3'b101, 4'd1,  4'd2,  32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 1'b1, 4'd1,  4'd2,  32'hA5A5_A5A5, 32'h5A5A_5A5A};

      reset = 1'b1;
      if0.start = 1'b0; if0.cmd = '0; if0.rd_lo = '0; if0.rd_hi = '0; if0.flush = 1'b0;
      if0.mul_y = '0; if0.mul_aux = '0;
      if1.start = 1'b0; if1.cmd = '0; if1.rd_lo = '0; if1.rd_hi = '0; if1.flush = 1'b0;
      if1.mul_y = '0; if1.mul_aux = '0;
      repeat (3) @(negedge clk);
      chk_idle0("reset");
      chk("reset.dut1.busy", 32'(if1.busy), 32'd0);
      chk("reset.dut1.we",   32'(if1.we),   32'd0);
      reset = 1'b0;

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // Flush during WAIT of an SMLAL
      @(negedge clk);
      if0.start = 1'b1; if0.cmd = 3'b111; if0.rd_lo = 4'd8; if0.rd_hi = 4'd9;
      if0.mul_y = 32'h1357_9BDF; if0.mul_aux = 32'h2468_ACE0;
      @(negedge clk);
      if0.start = 1'b0;
      chk("flush.c1.busy", 32'(if0.busy), 32'd1);
      if0.flush = 1'b1;
      @(negedge clk);
      if0.flush = 1'b0;
      chk_idle0("flush.c2");
      @(negedge clk);
      chk_idle0("flush.c3");
      @(negedge clk);
      chk_idle0("flush.c4");

      // Reset during WB_LO of a UMLAL
      @(negedge clk);
      if0.start = 1'b1; if0.cmd = 3'b101; if0.rd_lo = 4'd10; if0.rd_hi = 4'd11;
      if0.mul_y = 32'h0F0F_0F0F; if0.mul_aux = 32'hF0F0_F0F0;
      @(negedge clk);
      if0.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst.c3.we", 32'(if0.we), 32'd1);
      chk("rst.c3.wd", if0.wd,      32'h0F0F_0F0F);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk_idle0("rst.c4");
      @(negedge clk);
      chk_idle0("rst.c5");

      // LATENCY=1 back-to-back, with a stray start while busy
      @(negedge clk);
      if1.start = 1'b1; if1.cmd = 3'b000; if1.rd_lo = 4'd2; if1.mul_y = 32'h0000_00AA;
      @(negedge clk);
      chk("b2b.c1.busy", 32'(if1.busy),   32'd1);
      chk("b2b.c1.mop",  32'(if1.mul_op), 32'd1);
      if1.cmd = 3'b001; if1.rd_lo = 4'd12;
      @(negedge clk);
      if1.start = 1'b0;
      chk("b2b.c2.we",   32'(if1.we),   32'd1);
      chk("b2b.c2.wa",   32'(if1.wa),   32'd2);
      chk("b2b.c2.wd",   if1.wd,        32'h0000_00AA);
      chk("b2b.c2.done", 32'(if1.done), 32'd1);
      if1.mul_y = 32'h0000_00BB;
      @(negedge clk);
      chk("b2b.c3.busy", 32'(if1.busy), 32'd0);
      chk("b2b.c3.we",   32'(if1.we),   32'd0);
      if1.start = 1'b1; if1.cmd = 3'b001; if1.rd_lo = 4'd13;
      @(negedge clk);
      if1.start = 1'b0;
      chk("b2b.c4.busy", 32'(if1.busy),    32'd1);
      chk("b2b.c4.mcmd", 32'(if1.mul_cmd), 32'd1);
      chk("b2b.c4.we",   32'(if1.we),      32'd0);
      @(negedge clk);
      chk("b2b.c5.we",   32'(if1.we),   32'd1);
      chk("b2b.c5.wa",   32'(if1.wa),   32'd13);
      chk("b2b.c5.wd",   if1.wd,        32'h0000_00BB);
      chk("b2b.c5.done", 32'(if1.done), 32'd1);
      @(negedge clk);
      chk("b2b.c6.busy", 32'(if1.busy), 32'd0);
      chk("b2b.c6.we",   32'(if1.we),   32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
